// File: rtl/instruction_encoder_if.sv
// Handshake bundle between a request producer, the instruction encoder and
// the instruction-memory write port. The encoder takes the slave view.
interface instruction_encoder_if #(
    parameter int ADDR_W = 8
);
    // Request side: instruction fields offered by the producer
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_alu_op;
    logic [4:0]        in_dst;
    logic [4:0]        in_src1;
    logic [4:0]        in_src2;
    logic [31:0]       in_imm;

    // Memory write side
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_instr;

    // Status
    logic              err;
    logic [7:0]        err_count;
    logic [15:0]       written;

    // Producer / memory side of the link
    modport master (
        output in_valid, in_alu_op, in_dst, in_src1, in_src2, in_imm, out_ready,
        input  in_ready, out_valid, out_addr, out_instr, err, err_count, written
    );

    // Encoder side of the link
    modport slave (
        input  in_valid, in_alu_op, in_dst, in_src1, in_src2, in_imm, out_ready,
        output in_ready, out_valid, out_addr, out_instr, err, err_count, written
    );
endinterface

// File: rtl/instruction_encoder.sv
// Buffered instruction encoder for SemiCPU. Requests are checked and packed
// into 32-bit words, queued in a small FIFO, and streamed to the instruction
// memory with an auto-incrementing address. Rejected requests are counted.
module instruction_encoder #(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 8,
    parameter int START_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_encoder_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    // ALU operation codes as they arrive on in_alu_op
    localparam logic [2:0] OP_NOOP   = 3'b000;
    localparam logic [2:0] OP_ILLEGAL = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_SHIFTL = 3'b100;
    localparam logic [2:0] OP_SHIFTR = 3'b101;
    localparam logic [2:0] OP_ADDI   = 3'b110;
    localparam logic [2:0] OP_SUBI   = 3'b111;

    // FIFO storage and bookkeeping
    logic [31:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    // Output address and status registers
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_err;
    logic [7:0]        r_err_count;
    logic [15:0]       r_written;

    // Decode / handshake wires
    logic [3:0]        w_opcode;
    logic              w_is_itype;
    logic              w_imm_ok;
    logic              w_legal;
    logic [31:0]       w_word;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_push;
    logic              w_reject;
    logic              w_pop;

    // Translate the ALU operation into the decode-stage opcode and check
    // legality. The immediate must fit in 18 signed bits, i.e. bits 31..17
    // must all carry the same value.
    always_comb begin
        w_opcode   = 4'b0000;
        w_is_itype = 1'b0;
        case (bus.in_alu_op)
            OP_NOOP:   w_opcode = 4'b0000;
            OP_ADD:    w_opcode = 4'b0010;
            OP_SUB:    w_opcode = 4'b0011;
            OP_SHIFTL: w_opcode = 4'b0100;
            OP_SHIFTR: w_opcode = 4'b0101;
            OP_ADDI: begin
                w_opcode   = 4'b1100;
                w_is_itype = 1'b1;
            end
            OP_SUBI: begin
                w_opcode   = 4'b1111;
                w_is_itype = 1'b1;
            end
            default:   w_opcode = 4'b0000;
        endcase

        w_imm_ok = (&bus.in_imm[31:17]) | ~(|bus.in_imm[31:17]);
        w_legal  = (bus.in_alu_op != OP_ILLEGAL) && (!w_is_itype || w_imm_ok);
    end

    // Pack the fields into the instruction word. NOOP is all zeros no matter
    // what the other fields carry; I-type reuses the src2 slot for the
    // immediate.
    always_comb begin
        w_word = 32'h0000_0000;
        if (bus.in_alu_op == OP_NOOP) begin
            w_word = 32'h0000_0000;
        end else if (w_is_itype) begin
            w_word = {w_opcode, bus.in_dst, bus.in_src1, bus.in_imm[17:0]};
        end else begin
            w_word = {w_opcode, bus.in_dst, bus.in_src1, bus.in_src2, 13'b0};
        end
    end

    // Handshakes come only from registered occupancy, so a pop in the same
    // cycle never frees a slot for an incoming request.
    assign w_in_ready  = (r_count != FULL_COUNT);
    assign w_out_valid = (r_count != '0);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_push      = w_accept && w_legal;
    assign w_reject    = w_accept && !w_legal;
    assign w_pop       = w_out_valid && bus.out_ready;

    // FIFO storage: cleared on reset so the head reads zero until the first
    // word is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the
    // count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Write address and completed-write counter advance on each output
    // handshake; both wrap silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_addr <= ADDR_W'(START_ADDR);
            r_written  <= 16'd0;
        end else if (w_pop) begin
            r_out_addr <= r_out_addr + 1'b1;
            r_written  <= r_written + 16'd1;
        end
    end

    // Sticky error flag and saturating reject counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else if (w_reject) begin
            r_err <= 1'b1;
            if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_instr = r_mem[r_rd_ptr];
    assign bus.err       = r_err;
    assign bus.err_count = r_err_count;
    assign bus.written   = r_written;
endmodule
